cnn_layer_sequencer: RTL and testbench
======================================

// Module: cnn_layer_sequencer
// PURPOSE
// Parametrised instruction sequencer for the CNN accelerator. Fetches instructions from a
// synchronous instruction ROM and dispatches each to one of NUM_UNITS engines (weight fill,
// FIFO fill, conv, maxpool, refill, ...) via a start/done handshake. Supports per-instruction
// repeat (channel loop), HALT/NOP, an illegal-opcode trap and a done-wait timeout.
// PARAMETERS
// INSTR_W    64  instruction width; fields: [4:0] opcode, [12:5] repeat, [INSTR_W-1:13] arg
// IMEM_AW    8   instruction ROM address width
// NUM_UNITS  6   dispatchable engines; opcode k (1..NUM_UNITS) targets unit k-1; max 30
// TIMEOUT    4096  max WAIT_DONE cycles before trap; 0 disables timeout
// TO_W       16  timeout counter width; must satisfy TIMEOUT < 2**TO_W
// PORTS
// clk        in   1            clock, rising edge
// reset      in   1            asynchronous, active-low
// start      in   1            start program; sampled only in IDLE
// base_addr  in   IMEM_AW      first instruction address
// num_instrs in   IMEM_AW+1    program length; 0 = empty program
// imem_rd    out  1            ROM read strobe
// imem_addr  out  IMEM_AW      ROM address
// imem_data  in   INSTR_W      ROM data, valid exactly 1 cycle after imem_rd
// unit_start out  NUM_UNITS    one-hot, 1-cycle start pulse
// unit_arg   out  INSTR_W-13   operand field of current instruction; held through WAIT_DONE
// unit_iter  out  8            current repeat index (0..repeat)
// unit_done  in   NUM_UNITS    per-unit completion pulse/level
// busy       out  1            high in every state except IDLE
// done       out  1            program completed; sticky until next accepted start
// error      out  1            trapped; sticky until next accepted start
// err_code   out  2            1 illegal opcode, 2 timeout, 3 done from non-selected unit
// pc         out  IMEM_AW+1    index of current instruction (relative to base_addr)
// BEHAVIOUR
// - Reset (async): state IDLE; all outputs 0; pc 0, iter 0, timeout counter 0. Reset mid-run
//   abandons the program immediately; no further unit_start is issued.
// - States: IDLE, FETCH, MEMWAIT, DECODE, ISSUE, WAITDONE, FIN, TRAP.
// - IDLE: start=1 -> clear done/error/err_code, pc<=0, iter<=0 -> FETCH. start in any other
//   state is ignored.
// - FETCH: if pc>=num_instrs -> FIN (no read issued); else imem_rd=1,
//   imem_addr=base_addr+pc (mod 2**IMEM_AW) for one cycle -> MEMWAIT.
// - MEMWAIT: latch imem_data into instruction register -> DECODE.
// - DECODE: op 0 NOP -> pc++, FETCH; op 1..NUM_UNITS -> iter<=0, ISSUE; op 31 HALT -> FIN;
//   any other op -> TRAP, err_code 1.
// - ISSUE: unit_start[op-1]=1 for exactly one cycle; timeout counter cleared -> WAITDONE.
// - WAITDONE: unit_done[op-1]=1 -> if iter==repeat: pc++, FETCH; else iter++, ISSUE. Done
//   from any other unit -> TRAP, err_code 3 (takes priority over selected done). Counter
//   increments each cycle; TIMEOUT!=0 and counter reaches TIMEOUT with no done -> TRAP, code 2.
//   Selected done arriving in the same cycle as timeout wins (no trap).
// - Min dispatch latency: start-to-unit_start = 4 cycles (FETCH, MEMWAIT, DECODE, ISSUE).
// - Repeat field r yields r+1 start pulses; unit_iter = 0..r, valid from ISSUE through WAITDONE.
// - FIN: done=1 -> IDLE. TRAP: error=1, err_code held -> IDLE. busy=0 in IDLE only.
// - unit_arg/unit_iter change only in DECODE/ISSUE; stable while any unit is running.
// TESTING
// - base=8, num=3, ops {1,3,31}: expect one unit_start on bits 0 and 2, done, no read at addr 11.
// - op 3, repeat=2: exactly 3 unit_start[2] pulses, unit_iter 0,1,2; pc advances once.
// - num_instrs=0: start -> done after 2 cycles, imem_rd never asserted.
// - op 9 with NUM_UNITS=6: error=1, err_code=1, no unit_start; next start clears error.
// - TIMEOUT=16, unit_done held 0: error, err_code=2 after 16 WAITDONE cycles; done at cycle 16 -> no trap.
// - reset low during WAITDONE: all outputs 0 asynchronously; start pulse while busy ignored.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// Instruction sequencer for the CNN accelerator: fetches from a synchronous ROM and
// dispatches each instruction to an engine via start/done, with repeat, halt and traps.
module cnn_layer_sequencer #(
    parameter int INSTR_W   = 64,
    parameter int IMEM_AW   = 8,
    parameter int NUM_UNITS = 6,
    parameter int TIMEOUT   = 4096,
    parameter int TO_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [IMEM_AW-1:0]   base_addr,
    input  logic [IMEM_AW:0]     num_instrs,
    output logic                 imem_rd,
    output logic [IMEM_AW-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [INSTR_W-14:0]  unit_arg,
    output logic [7:0]           unit_iter,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [IMEM_AW:0]     pc
);
    localparam int ARG_W = INSTR_W - 13;
    localparam logic [4:0]      OP_NOP   = 5'd0;
    localparam logic [4:0]      OP_HALT  = 5'd31;
    localparam logic [4:0]      OP_LAST  = 5'(NUM_UNITS);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
    localparam logic [IMEM_AW:0] PC_ONE  = (IMEM_AW+1)'(1);
    localparam bit              TO_EN    = (TIMEOUT != 0);

    typedef struct packed {
        logic [ARG_W-1:0] arg;
        logic [7:0]       rpt;
        logic [4:0]       op;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_MEMWAIT, S_DECODE, S_ISSUE, S_WAITDONE, S_FIN, S_TRAP
    } state_t;

    state_t               state, state_nxt;
    instr_t               ir;
    logic [IMEM_AW-1:0]   base_q;
    logic [IMEM_AW:0]     num_q;
    logic [7:0]           iter;
    logic [TO_W-1:0]      to_cnt, to_cnt_inc;
    logic [NUM_UNITS-1:0] sel;
    logic [1:0]           trap_code;
    logic                 prog_end, op_is_unit;
    logic                 pc_inc, iter_clr, iter_inc, arg_ld;

    // Decoded one-hot engine select for the instruction in the register.
    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_sel
        assign sel[k] = (ir.op == 5'(k + 1));
    end

    assign prog_end   = (pc >= num_q);
    assign op_is_unit = (ir.op != OP_NOP) && (ir.op <= OP_LAST);
    assign to_cnt_inc = to_cnt + TO_ONE;

    assign busy       = (state != S_IDLE);
    assign imem_rd    = (state == S_FETCH) && !prog_end;
    assign imem_addr  = imem_rd ? (base_q + pc[IMEM_AW-1:0]) : '0;
    assign unit_start = (state == S_ISSUE) ? sel : '0;
    assign unit_iter  = iter;

    always_comb begin
        state_nxt = state;
        trap_code = 2'd0;
        pc_inc    = 1'b0;
        iter_clr  = 1'b0;
        iter_inc  = 1'b0;
        arg_ld    = 1'b0;
        case (state)
            S_IDLE:    if (start) state_nxt = S_FETCH;
            S_FETCH:   state_nxt = prog_end ? S_FIN : S_MEMWAIT;
            S_MEMWAIT: state_nxt = S_DECODE;
            S_DECODE: begin
                if (ir.op == OP_NOP) begin
                    pc_inc    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (op_is_unit) begin
                    iter_clr  = 1'b1;
                    arg_ld    = 1'b1;
                    state_nxt = S_ISSUE;
                end else if (ir.op == OP_HALT) begin
                    state_nxt = S_FIN;
                end else begin
                    trap_code = 2'd1;
                    state_nxt = S_TRAP;
                end
            end
            S_ISSUE:   state_nxt = S_WAITDONE;
            S_WAITDONE: begin
                // Foreign done outranks the selected one; selected done outranks timeout.
                if (|(unit_done & ~sel)) begin
                    trap_code = 2'd3;
                    state_nxt = S_TRAP;
                end else if (|(unit_done & sel)) begin
                    if (iter == ir.rpt) begin
                        pc_inc    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        iter_inc  = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end else if (TO_EN && (to_cnt_inc == TO_LIMIT)) begin
                    trap_code = 2'd2;
                    state_nxt = S_TRAP;
                end
            end
            S_FIN:     state_nxt = S_IDLE;
            S_TRAP:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ir       <= '0;
            base_q   <= '0;
            num_q    <= '0;
            pc       <= '0;
            iter     <= '0;
            to_cnt   <= '0;
            unit_arg <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                pc       <= '0;
                iter     <= '0;
                done     <= 1'b0;
                error    <= 1'b0;
                err_code <= 2'd0;
                base_q   <= base_addr;
                num_q    <= num_instrs;
            end
            if (state == S_MEMWAIT) ir <= instr_t'(imem_data);
            if (pc_inc) pc <= pc + PC_ONE;
            if (iter_clr)      iter <= '0;
            else if (iter_inc) iter <= iter + 8'd1;
            // Operand only moves when a new engine instruction is decoded.
            if (arg_ld) unit_arg <= ir.arg;
            if (state == S_ISSUE)         to_cnt <= '0;
            else if (state == S_WAITDONE) to_cnt <= to_cnt_inc;
            if (state_nxt == S_FIN) done <= 1'b1;
            if (state_nxt == S_TRAP) begin
                error    <= 1'b1;
                err_code <= trap_code;
            end
        end
    end
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: expected ROM reads, unit starts and
// program endings are queued by the stimulus and checked by a negedge monitor.
module tb_cnn_layer_sequencer;
    localparam int NU    = 6;
    localparam int ARG_W = 51;

    localparam int EV_RD  = 0;
    localparam int EV_ST  = 1;
    localparam int EV_END = 2;

    typedef struct {
        int               kind;
        logic [63:0]      val;
        logic [ARG_W-1:0] arg;
        logic [7:0]       iter;
        int               off;
        string            name;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       base_addr = '0;
    logic [8:0]       num_instrs = '0;
    logic             imem_rd;
    logic [7:0]       imem_addr;
    logic [63:0]      imem_data = '0;
    logic [NU-1:0]    unit_start;
    logic [ARG_W-1:0] unit_arg;
    logic [7:0]       unit_iter;
    logic [NU-1:0]    unit_done;
    logic             busy, done, error;
    logic [1:0]       err_code;
    logic [8:0]       pc;

    logic [63:0] rom [256];
    ev_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    logic        done_p = 1'b0;
    logic        error_p = 1'b0;
    logic        resp_en = 1'b1;
    logic        resp_wrong = 1'b0;
    int          resp_delay = 1;

    cnn_layer_sequencer #(
        .INSTR_W(64), .IMEM_AW(8), .NUM_UNITS(NU), .TIMEOUT(16), .TO_W(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_instrs(num_instrs), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_data(imem_data), .unit_start(unit_start), .unit_arg(unit_arg),
        .unit_iter(unit_iter), .unit_done(unit_done), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .pc(pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (imem_rd) imem_data <= rom[imem_addr];

    function automatic logic [63:0] mk(input logic [4:0] op, input logic [7:0] r,
                                       input logic [ARG_W-1:0] a);
        return {a, r, op};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic push(input int kind, input logic [63:0] val, input logic [ARG_W-1:0] arg,
                        input logic [7:0] iter, input int off, input string name);
        ev_t e;
        e.kind = kind; e.val = val; e.arg = arg; e.iter = iter; e.off = off; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input logic [63:0] val, input logic [ARG_W-1:0] arg,
                       input logic [7:0] iter);
        ev_t e;
        int  off;
        off = cyc - start_cyc;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected event: kind=%0d val=%0h arg=%0h iter=%0d off=%0d",
                     kind, val, arg, iter, off);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.arg !== arg || e.iter !== iter || e.off != off) begin
                bad++;
                $display("FAIL %s: got kind=%0d val=%0h arg=%0h iter=%0d off=%0d want kind=%0d val=%0h arg=%0h iter=%0d off=%0d",
                         e.name, kind, val, arg, iter, off, e.kind, e.val, e.arg, e.iter, e.off);
            end
        end
    endtask

    // Monitor: at most one observable event per cycle (each lives in a distinct state).
    always @(negedge clk) begin
        if (reset) begin
            if (imem_rd) got(EV_RD, 64'(imem_addr), '0, '0);
            if (|unit_start) got(EV_ST, 64'(unit_start), unit_arg, unit_iter);
            if ((done && !done_p) || (error && !error_p))
                got(EV_END, 64'({done, error, err_code}), ARG_W'(pc), '0);
        end
        done_p  = done;
        error_p = error;
    end

    // Engine model: pulse done resp_delay cycles into WAITDONE, optionally from the wrong unit.
    initial begin
        int            rcnt;
        logic [NU-1:0] rmask;
        rcnt = 0;
        rmask = '0;
        unit_done = '0;
        forever begin
            @(negedge clk);
            unit_done = '0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) unit_done = rmask;
            end
            if (resp_en && |unit_start) begin
                rcnt  = resp_delay;
                rmask = resp_wrong ? {unit_start[NU-2:0], unit_start[NU-1]} : unit_start;
            end
        end
    end

    task automatic run_prog(input logic [7:0] b, input logic [8:0] n);
        int k;
        @(negedge clk);
        base_addr = b; num_instrs = n; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_error", 64'({error, err_code}), 64'd0);
        k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("prog_finished", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[0]   = mk(5'd6, 8'd0, 51'h0D0D);
        rom[1]   = mk(5'd3, 8'd2, 51'h0C0C);
        rom[8]   = mk(5'd1, 8'd0, 51'h1234);
        rom[9]   = mk(5'd3, 8'd0, 51'h7ABCDEF012345);
        rom[10]  = mk(5'd31, 8'd0, 51'h0);
        rom[11]  = mk(5'd2, 8'd0, 51'hBAD);
        rom[20]  = mk(5'd9, 8'd0, 51'h99);
        rom[30]  = mk(5'd1, 8'd0, 51'h0F0F);
        rom[40]  = mk(5'd2, 8'd0, 51'h0606);
        rom[60]  = mk(5'd4, 8'd0, 51'h0E0E);
        rom[255] = mk(5'd0, 8'd0, 51'h55);

        // Reset state
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outs", 64'({imem_rd, unit_start, done, error, err_code}), 64'd0);
        chk("rst_pc_iter", 64'({pc, unit_iter}), 64'd0);
        chk("rst_arg", 64'(unit_arg), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Two engines then HALT; the read at 11 must never appear
        resp_en = 1'b1; resp_wrong = 1'b0; resp_delay = 2;
        push(EV_RD, 64'd8, '0, 8'd0, 1, "t1_rd8");
        push(EV_ST, 64'd1, 51'h1234, 8'd0, 4, "t1_st_u0");
        push(EV_RD, 64'd9, '0, 8'd0, 7, "t1_rd9");
        push(EV_ST, 64'd4, 51'h7ABCDEF012345, 8'd0, 10, "t1_st_u2");
        push(EV_RD, 64'd10, '0, 8'd0, 13, "t1_rd10");
        push(EV_END, 64'h8, 51'd2, 8'd0, 16, "t1_end");
        run_prog(8'd8, 9'd3);

        // Repeat field 2 -> three starts, one pc advance
        resp_delay = 1;
        push(EV_RD, 64'd1, '0, 8'd0, 1, "t2_rd1");
        push(EV_ST, 64'd4, 51'h0C0C, 8'd0, 4, "t2_it0");
        push(EV_ST, 64'd4, 51'h0C0C, 8'd1, 6, "t2_it1");
        push(EV_ST, 64'd4, 51'h0C0C, 8'd2, 8, "t2_it2");
        push(EV_END, 64'h8, 51'd1, 8'd0, 11, "t2_end");
        run_prog(8'd1, 9'd1);

        // Empty program
        push(EV_END, 64'h8, 51'd0, 8'd0, 2, "t3_empty_end");
        run_prog(8'd100, 9'd0);

        // Illegal opcode 9
        push(EV_RD, 64'd20, '0, 8'd0, 1, "t4_rd20");
        push(EV_END, 64'h5, 51'd0, 8'd0, 4, "t4_illegal");
        run_prog(8'd20, 9'd2);

        // Timeout with no done (error from t4 cleared by this start)
        resp_en = 1'b0;
        push(EV_RD, 64'd30, '0, 8'd0, 1, "t5_rd30");
        push(EV_ST, 64'd1, 51'h0F0F, 8'd0, 4, "t5_st");
        push(EV_END, 64'h6, 51'd0, 8'd0, 21, "t5_timeout");
        run_prog(8'd30, 9'd1);

        // Done in the 16th wait cycle beats the timeout
        resp_en = 1'b1; resp_delay = 16;
        push(EV_RD, 64'd30, '0, 8'd0, 1, "t6_rd30");
        push(EV_ST, 64'd1, 51'h0F0F, 8'd0, 4, "t6_st");
        push(EV_END, 64'h8, 51'd1, 8'd0, 22, "t6_end");
        run_prog(8'd30, 9'd1);

        // Done from a non-selected unit
        resp_delay = 1; resp_wrong = 1'b1;
        push(EV_RD, 64'd40, '0, 8'd0, 1, "t7_rd40");
        push(EV_ST, 64'd2, 51'h0606, 8'd0, 4, "t7_st");
        push(EV_END, 64'h7, 51'd0, 8'd0, 6, "t7_wrong_done");
        run_prog(8'd40, 9'd1);

        // NOP then an address wrap 255 -> 0
        resp_wrong = 1'b0;
        push(EV_RD, 64'd255, '0, 8'd0, 1, "t8_rd255");
        push(EV_RD, 64'd0, '0, 8'd0, 4, "t8_rd0_wrap");
        push(EV_ST, 64'd32, 51'h0D0D, 8'd0, 7, "t8_st_u5");
        push(EV_END, 64'h8, 51'd2, 8'd0, 10, "t8_end");
        run_prog(8'd255, 9'd2);

        // Reset during WAITDONE; a start while busy must be ignored
        resp_en = 1'b0;
        push(EV_RD, 64'd60, '0, 8'd0, 1, "t9_rd60");
        push(EV_ST, 64'd8, 51'h0E0E, 8'd0, 4, "t9_st");
        @(negedge clk);
        base_addr = 8'd60; num_instrs = 9'd1; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t9_busy_before", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("t9_rst_busy", 64'(busy), 64'd0);
        chk("t9_rst_outs", 64'({imem_rd, unit_start, done, error, err_code}), 64'd0);
        chk("t9_rst_pc_iter", 64'({pc, unit_iter}), 64'd0);
        chk("t9_rst_arg", 64'(unit_arg), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("t9_idle_after", 64'(busy), 64'd0);
        chk("t9_queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
